// File: rtl/se_channel_scale.sv
// se_channel_scale: squeeze-and-excite output stage.
// Loads one frame's per-channel gate vector (clamped to [0, 1.0]), then
// multiplies each channel-interleaved feature beat by its channel's gate.
// Optional build macro SE_SCALE_ROUND_EN selects round-half-up instead of
// floor on the Q-format rescale; latency and handshake do not change.
module se_channel_scale #(
  parameter int DATA_WIDTH   = 8,
  parameter int FRAC_BITS    = 4,
  parameter int NUM_CHANNELS = 16,
  parameter int NUM_PIXELS   = 49
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gate_in,
  input  logic                  gate_valid_in,
  input  logic [DATA_WIDTH-1:0] feat_in,
  input  logic                  feat_valid_in,
  output logic                  feat_ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  gates_loaded
);

  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int MW = 2 * DATA_WIDTH;

  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CHANNELS - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NUM_PIXELS - 1);
  localparam logic [DATA_WIDTH-1:0] GATE_ONE = DATA_WIDTH'(1 << FRAC_BITS);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_SCALE = 1'b1;

  // Gates are only meaningful in [0, 1.0]; anything outside is pinned to the range.
  function automatic logic [DATA_WIDTH-1:0] clamp_gate(input logic [DATA_WIDTH-1:0] g);
    logic [DATA_WIDTH-1:0] r;
    if ($signed(g) < $signed({DATA_WIDTH{1'b0}})) begin
      r = {DATA_WIDTH{1'b0}};
    end else if ($signed(g) > $signed(GATE_ONE)) begin
      r = GATE_ONE;
    end else begin
      r = g;
    end
    return r;
  endfunction

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         gate_cnt_q, gate_cnt_d;
  logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
  logic [PW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] gate_buf_q [NUM_CHANNELS];

  logic                  gate_we_s;
  logic [DATA_WIDTH-1:0] gate_wdata_s;
  logic signed [MW-1:0]  feat_ext_s;
  logic signed [MW-1:0]  gate_ext_s;
  logic signed [MW-1:0]  prod_s;
  logic signed [MW-1:0]  scaled_s;

  // Full-precision product; the gate is non-negative so the result always fits DATA_WIDTH.
  assign feat_ext_s = {{DATA_WIDTH{feat_in[DATA_WIDTH-1]}}, feat_in};
  assign gate_ext_s = {{DATA_WIDTH{gate_buf_q[ch_cnt_q][DATA_WIDTH-1]}}, gate_buf_q[ch_cnt_q]};
  assign prod_s     = feat_ext_s * gate_ext_s;
`ifdef SE_SCALE_ROUND_EN
  assign scaled_s   = (prod_s + MW'(1 << (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
  assign scaled_s   = prod_s >>> FRAC_BITS;
`endif

  assign gate_wdata_s   = clamp_gate(gate_in);
  assign feat_ready_out = (state_q == ST_SCALE);
  assign gates_loaded   = (state_q == ST_SCALE);
  assign data_out       = data_q;
  assign valid_out      = valid_q;
  assign frame_done     = done_q;

  // Next-state logic: gate capture in LOAD, per-beat scaling and frame counting in SCALE.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    ch_cnt_d   = ch_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    gate_we_s  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (gate_valid_in) begin
          gate_we_s = 1'b1;
          if (gate_cnt_q == CH_LAST) begin
            gate_cnt_d = {CW{1'b0}};
            state_d    = ST_SCALE;
          end else begin
            gate_cnt_d = gate_cnt_q + CW'(1);
          end
        end else begin
          gate_we_s = 1'b0;
        end
      end
      ST_SCALE: begin
        if (feat_valid_in) begin
          valid_d = 1'b1;
          data_d  = scaled_s[DATA_WIDTH-1:0];
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = {CW{1'b0}};
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_d = {PW{1'b0}};
              state_d   = ST_LOAD;
              done_d    = 1'b1;
            end else begin
              pix_cnt_d = pix_cnt_q + PW'(1);
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CW'(1);
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and output registers; reset abandons any in-flight frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      gate_cnt_q <= {CW{1'b0}};
      ch_cnt_q   <= {CW{1'b0}};
      pix_cnt_q  <= {PW{1'b0}};
      data_q     <= {DATA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      ch_cnt_q   <= ch_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  // Gate buffer write port; contents need no reset since LOAD rewrites every entry.
  always_ff @(posedge clk) begin
    if (gate_we_s && !rst) begin
      gate_buf_q[gate_cnt_q] <= gate_wdata_s;
    end
  end

endmodule

// File: tb/tb_se_channel_scale.sv
// Self-checking bench for se_channel_scale (default parameters).
module tb_se_channel_scale;
  localparam int DW    = 8;
  localparam int FB    = 4;
  localparam int NC    = 16;
  localparam int NP    = 49;
  localparam int FRAME = NC * NP;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] gate_in;
  logic          gate_valid_in;
  logic [DW-1:0] feat_in;
  logic          feat_valid_in;
  logic          feat_ready_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          frame_done;
  logic          gates_loaded;

  int checks = 0;
  int errors = 0;
  int gates_m [NC];

  always #5 clk = ~clk;

  se_channel_scale #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_CHANNELS(NC), .NUM_PIXELS(NP)) dut (
    .clk(clk), .rst(rst), .gate_in(gate_in), .gate_valid_in(gate_valid_in),
    .feat_in(feat_in), .feat_valid_in(feat_valid_in), .feat_ready_out(feat_ready_out),
    .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done),
    .gates_loaded(gates_loaded)
  );

  function automatic int clamp_m(int g);
    if (g < 0) return 0;
    if (g > (1 << FB)) return 1 << FB;
    return g;
  endfunction

  // Reference: feature times gate divided by 2^FB, floor (or round half up).
  function automatic int scale_m(int f, int g);
    int p;
    int q;
    p = f * g;
`ifdef SE_SCALE_ROUND_EN
    p = p + (1 << (FB - 1));
`endif
    q = p / (1 << FB);
    if ((p % (1 << FB) != 0) && (p < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int rand_s8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic do_reset();
    rst = 1'b1; gate_valid_in = 1'b0; feat_valid_in = 1'b0;
    gate_in = 8'd0; feat_in = 8'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives a gate vector (feature beats offered throughout); reports any output/ready seen.
  task automatic load_gates(input int raw [NC], input int max_gap, output int outs, output int rdys);
    outs = 0; rdys = 0;
    for (int i = 0; i < NC; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      for (int k = 0; k < gap; k++) begin
        gate_valid_in = 1'b0; feat_valid_in = 1'b1; feat_in = 8'(rand_s8());
        if (feat_ready_out) rdys++;
        @(posedge clk); @(negedge clk);
        if (valid_out) outs++;
      end
      gate_valid_in = 1'b1; gate_in = 8'(raw[i]);
      feat_valid_in = 1'b1; feat_in = 8'(rand_s8());
      if (feat_ready_out) rdys++;
      @(posedge clk); @(negedge clk);
      if (valid_out) outs++;
      gates_m[i] = clamp_m(raw[i]);
    end
    gate_valid_in = 1'b0; feat_valid_in = 1'b0;
  endtask

  task automatic beat(input int f, input logic gv);
    feat_valid_in = 1'b1; feat_in = 8'(f);
    gate_valid_in = gv; gate_in = 8'($urandom_range(40));
    @(posedge clk); @(negedge clk);
    feat_valid_in = 1'b0; gate_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({data_out, valid_out, frame_done, gates_loaded, feat_ready_out} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%0d valid=%0b done=%0b loaded=%0b ready=%0b, want all 0",
               data_out, valid_out, frame_done, gates_loaded, feat_ready_out);
    end
  endtask

  task automatic test_unity();
    int raw [NC];
    int outs, rdys;
    do_reset();
    for (int i = 0; i < NC; i++) raw[i] = 16;
    load_gates(raw, 0, outs, rdys);
    checks++;
    if (outs !== 0 || rdys !== 0) begin
      errors++; $display("FAIL unity_load_quiet: outputs=%0d ready_cycles=%0d, want 0 and 0", outs, rdys);
    end
    checks++;
    if (feat_ready_out !== 1'b1 || gates_loaded !== 1'b1) begin
      errors++; $display("FAIL unity_ready: ready=%0b loaded=%0b, want 1 1", feat_ready_out, gates_loaded);
    end
    beat(40, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'd40) begin
      errors++; $display("FAIL unity_beat: valid=%0b data=%0d, want 1 40", valid_out, $signed(data_out));
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'd40) begin
      errors++; $display("FAIL unity_idle_hold: valid=%0b data=%0d, want 0 40", valid_out, $signed(data_out));
    end
  endtask

  task automatic test_half_and_max();
    int raw [NC];
    int outs, rdys;
    logic [DW-1:0] want;
    do_reset();
    for (int i = 0; i < NC; i++) raw[i] = int'($urandom_range(35)) - 10;
    raw[0] = 8; raw[1] = 16;
    load_gates(raw, 2, outs, rdys);
`ifdef SE_SCALE_ROUND_EN
    want = 8'hFD;
`else
    want = 8'hFC;
`endif
    beat(-7, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== want) begin
      errors++; $display("FAIL half_gate: valid=%0b data=%0d, want 1 %0d", valid_out, $signed(data_out), $signed(want));
    end
    beat(127, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'd127) begin
      errors++; $display("FAIL max_feat: valid=%0b data=%0d, want 1 127", valid_out, $signed(data_out));
    end
  endtask

  task automatic test_clamp();
    int raw [NC];
    int outs, rdys;
    do_reset();
    for (int i = 0; i < NC; i++) raw[i] = int'($urandom_range(60)) - 30;
    raw[0] = 20; raw[1] = -5;
    load_gates(raw, 1, outs, rdys);
    beat(50, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'd50) begin
      errors++; $display("FAIL clamp_high: valid=%0b data=%0d, want 1 50", valid_out, $signed(data_out));
    end
    beat(50, 1'b0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'd0) begin
      errors++; $display("FAIL clamp_low: valid=%0b data=%0d, want 1 0", valid_out, $signed(data_out));
    end
    for (int c = 2; c < NC; c++) begin
      int f;
      f = rand_s8();
      beat(f, 1'b0);
      checks++;
      if (data_out !== 8'(scale_m(f, gates_m[c]))) begin
        errors++; $display("FAIL clamp_ch%0d: data=%0d, want %0d (f=%0d raw=%0d)", c, $signed(data_out),
                           scale_m(f, gates_m[c]), f, raw[c]);
      end
    end
  endtask

  // Whole frame with random gaps; optionally offers gate beats while scaling (incl. the last beat).
  task automatic test_frame(input bit gate_noise);
    int raw [NC];
    int outs, rdys;
    for (int i = 0; i < NC; i++) raw[i] = int'($urandom_range(50)) - 20;
    load_gates(raw, 3, outs, rdys);
    checks++;
    if (outs !== 0 || rdys !== 0) begin
      errors++; $display("FAIL frame_load_quiet: outputs=%0d ready_cycles=%0d, want 0 and 0", outs, rdys);
    end
    for (int k = 0; k < FRAME; k++) begin
      int f;
      int gap;
      logic gv;
      gap = int'($urandom_range(3)) == 0 ? int'($urandom_range(2)) + 1 : 0;
      for (int g = 0; g < gap; g++) begin
        gate_valid_in = gate_noise; gate_in = 8'($urandom_range(40));
        @(posedge clk); @(negedge clk);
        gate_valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin
          errors++; $display("FAIL frame_idle: beat %0d valid=%0b, want 0", k, valid_out);
        end
      end
      checks++;
      if (feat_ready_out !== 1'b1) begin
        errors++; $display("FAIL frame_ready: beat %0d ready=%0b, want 1", k, feat_ready_out);
      end
      f  = rand_s8();
      gv = gate_noise && ((k == FRAME - 1) || ($urandom_range(3) == 0));
      beat(f, gv);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 8'(scale_m(f, gates_m[k % NC])) ||
          frame_done !== (k == FRAME - 1)) begin
        errors++;
        $display("FAIL frame_beat: beat %0d valid=%0b data=%0d done=%0b, want 1 %0d %0b", k, valid_out,
                 $signed(data_out), frame_done, scale_m(f, gates_m[k % NC]), (k == FRAME - 1));
      end
    end
    checks++;
    if (feat_ready_out !== 1'b0 || gates_loaded !== 1'b0) begin
      errors++; $display("FAIL frame_end_state: ready=%0b loaded=%0b, want 0 0", feat_ready_out, gates_loaded);
    end
  endtask

  // Reload immediately after a frame that had gate beats offered during SCALE.
  task automatic test_back_to_back();
    int raw [NC];
    int outs, rdys;
    for (int i = 0; i < NC; i++) raw[i] = int'($urandom_range(17));
    load_gates(raw, 0, outs, rdys);
    checks++;
    if (outs !== 0 || feat_ready_out !== 1'b1) begin
      errors++; $display("FAIL b2b_load: outputs=%0d ready=%0b, want 0 1", outs, feat_ready_out);
    end
    for (int k = 0; k < 2 * NC; k++) begin
      int f;
      f = rand_s8();
      beat(f, 1'b0);
      checks++;
      if (valid_out !== 1'b1 || data_out !== 8'(scale_m(f, gates_m[k % NC])) || frame_done !== 1'b0) begin
        errors++; $display("FAIL b2b_beat: beat %0d valid=%0b data=%0d done=%0b, want 1 %0d 0", k, valid_out,
                           $signed(data_out), frame_done, scale_m(f, gates_m[k % NC]));
      end
    end
  endtask

  task automatic test_mid_reset();
    int raw [NC];
    int outs, rdys;
    do_reset();
    for (int i = 0; i < NC; i++) raw[i] = int'($urandom_range(16));
    load_gates(raw, 0, outs, rdys);
    for (int k = 0; k < 5; k++) beat(rand_s8() | 1, 1'b0);
    rst = 1'b1; feat_valid_in = 1'b1; feat_in = 8'd77;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; feat_valid_in = 1'b0;
    checks++;
    if ({data_out, valid_out, frame_done, gates_loaded, feat_ready_out} !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset: data=%0d valid=%0b done=%0b loaded=%0b ready=%0b, want all 0",
               data_out, valid_out, frame_done, gates_loaded, feat_ready_out);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (valid_out !== 1'b0 || feat_ready_out !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: valid=%0b ready=%0b, want 0 0", valid_out, feat_ready_out);
    end
    test_frame(1'b0);
  endtask

  initial begin
    rst = 1'b1; gate_in = 8'd0; gate_valid_in = 1'b0; feat_in = 8'd0; feat_valid_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_unity();
    test_half_and_max();
    test_clamp();
    do_reset();
    test_frame(1'b0);
    test_frame(1'b1);
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
